image_reader: RTL and testbench

IMAGE_READER -- requirements
Module: image_reader

---
 rtl/vip_pkg.sv | 31 +++
 rtl/image_scan_counter.sv | 63 ++++++
 rtl/image_reader.sv | 152 +++++++++++++++
 tb/tb_image_reader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vip_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vip_pkg
//  Description : Shared widths, reader state encoding and the frame-size
//                helper for the video input pipeline blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package vip_pkg;

  localparam int c_dwidth = 24;  // packed {R,G,B} pixel
  localparam int c_awidth = 22;  // pixel-memory word address
  localparam int c_gwidth = 11;  // width / height / frame count
  localparam int c_twidth = 33;  // holds width*height*num_frame

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

  // Total pixel reads needed for a job.
  function automatic logic [c_twidth-1:0] total_pixels(
    input logic [c_gwidth-1:0] w,
    input logic [c_gwidth-1:0] h,
    input logic [c_gwidth-1:0] n
  );
    return c_twidth'(w) * c_twidth'(h) * c_twidth'(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/image_scan_counter.sv
`default_nettype none
// ============================================================================
//  Module      : image_scan_counter
//  Description : Tracks x / y / frame position of pixels written downstream
//                and generates start-of-frame and end-of-line markers.
//  Revision    : 1.0 - initial release
// ============================================================================
module image_scan_counter
  import vip_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                advance,
  input  logic [c_gwidth-1:0] width,
  input  logic [c_gwidth-1:0] height,
  input  logic [c_gwidth-1:0] num_frame,
  output logic                sof,
  output logic                eol,
  output logic                last_pixel,
  output logic [c_gwidth-1:0] frame_cnt
);

  logic [c_gwidth-1:0] r_x;
  logic [c_gwidth-1:0] r_y;
  logic [c_gwidth-1:0] r_frame;
  logic                w_x_end;
  logic                w_y_end;

  assign w_x_end    = (r_x == width - c_gwidth'(1));
  assign w_y_end    = (r_y == height - c_gwidth'(1));
  assign sof        = advance && (r_x == '0) && (r_y == '0);
  assign eol        = advance && w_x_end;
  assign last_pixel = w_x_end && w_y_end && (r_frame == num_frame - c_gwidth'(1));
  assign frame_cnt  = r_frame;

  // Raster position advances by one pixel on every downstream write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_frame <= '0;
    end else if (clear) begin
      r_x     <= '0;
      r_y     <= '0;
      r_frame <= '0;
    end else if (advance) begin
      if (w_x_end) begin
        r_x <= '0;
        if (w_y_end) begin
          r_y     <= '0;
          r_frame <= r_frame + c_gwidth'(1);
        end else begin
          r_y <= r_y + c_gwidth'(1);
        end
      end else begin
        r_x <= r_x + c_gwidth'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/image_reader.sv
`default_nettype none
// ============================================================================
//  Module      : image_reader
//  Description : Streams num_frame frames of width x height pixels from a
//                linear pixel memory into a downstream FIFO, one pixel per
//                cycle, with a single-entry hold register absorbing the read
//                that returns while the FIFO is full.
//  Revision    : 1.0 - initial release
// ============================================================================
module image_reader
  import vip_pkg::*;
#(
  parameter int DWIDTH = c_dwidth,
  parameter int AWIDTH = c_awidth
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [c_gwidth-1:0] width,
  input  logic [c_gwidth-1:0] height,
  input  logic [c_gwidth-1:0] num_frame,
  input  logic                start,
  output logic                mem_rden,
  output logic [AWIDTH-1:0]   mem_addr,
  input  logic [DWIDTH-1:0]   mem_rdata,
  output logic                fifo_wrreq,
  output logic [DWIDTH-1:0]   fifo_data,
  input  logic                fifo_full,
  output logic                out_sof,
  output logic                out_eol,
  output logic                busy,
  output logic                done,
  output logic [c_gwidth-1:0] frame_cnt
);

  reader_state_t       r_state;
  logic [c_gwidth-1:0] r_width;
  logic [c_gwidth-1:0] r_height;
  logic [c_gwidth-1:0] r_num_frame;
  logic [c_twidth-1:0] r_reads_left;
  logic [AWIDTH-1:0]   r_mem_addr;
  logic                r_rd_pending;
  logic                r_hold_valid;
  logic [DWIDTH-1:0]   r_hold_data;
  logic                r_busy;
  logic                r_done;

  logic                w_start_zero;
  logic                w_start_ok;
  logic                w_issue;
  logic                w_write;
  logic                w_last_pixel;

  assign w_start_zero = (width == '0) || (height == '0) || (num_frame == '0);
  assign w_start_ok   = (r_state == IDLE) && start && !w_start_zero;

  // A read may only go out when its data is guaranteed a home next cycle:
  // FIFO not full now and the hold register free.
  assign w_issue = (r_state == READ) && (r_reads_left != '0) && !fifo_full && !r_hold_valid;

  // Held data and freshly returned data are never present together.
  assign w_write = !fifo_full && (r_hold_valid || r_rd_pending);

  assign mem_rden   = w_issue;
  assign mem_addr   = r_mem_addr;
  assign fifo_wrreq = w_write;
  assign fifo_data  = r_hold_valid ? r_hold_data : (r_rd_pending ? mem_rdata : '0);
  assign busy       = r_busy;
  assign done       = r_done;

  // Job control: accept start, issue reads, wait for the final write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_width      <= '0;
      r_height     <= '0;
      r_num_frame  <= '0;
      r_reads_left <= '0;
      r_mem_addr   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_start_zero) begin
              r_done <= 1'b1;
            end else begin
              r_width      <= width;
              r_height     <= height;
              r_num_frame  <= num_frame;
              r_reads_left <= total_pixels(width, height, num_frame);
              r_mem_addr   <= '0;
              r_busy       <= 1'b1;
              r_state      <= READ;
            end
          end
        end
        READ: begin
          if (w_issue) begin
            r_mem_addr   <= r_mem_addr + AWIDTH'(1);
            r_reads_left <= r_reads_left - c_twidth'(1);
            if (r_reads_left == c_twidth'(1)) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_write && w_last_pixel) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Track the in-flight read and park its data when the FIFO is full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_pending <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else begin
      r_rd_pending <= w_issue;
      if (r_rd_pending && fifo_full) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= mem_rdata;
      end else if (r_hold_valid && !fifo_full) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  image_scan_counter u_scan (
    .clock      (clock),
    .reset      (reset),
    .clear      (w_start_ok),
    .advance    (w_write),
    .width      (r_width),
    .height     (r_height),
    .num_frame  (r_num_frame),
    .sof        (out_sof),
    .eol        (out_eol),
    .last_pixel (w_last_pixel),
    .frame_cnt  (frame_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_image_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_image_reader
//  Description : Scoreboard bench for image_reader. A second instance with a
//                4-bit address bus exercises address wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_image_reader;

  localparam int DW  = 24;
  localparam int AW  = 22;
  localparam int AW2 = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic          sof;
    logic          eol;
    logic          last;
  } exp_t;

  logic          clock, reset, start, fifo_full;
  logic [10:0]   width, height, num_frame;
  logic          mem_rden, fifo_wrreq, out_sof, out_eol, busy, done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata, fifo_data;
  logic [10:0]   frame_cnt;

  logic           mem_rden2, fifo_wrreq2, out_sof2, out_eol2, busy2, done2;
  logic [AW2-1:0] mem_addr2;
  logic [DW-1:0]  mem_rdata2, fifo_data2;
  logic [10:0]    frame_cnt2;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  int   cur_n = 0;
  bit   zero_done_ok = 0;
  int   rd2_cnt = 0;
  int   wr2_cnt = 0;

  image_reader u_dut (
    .clock(clock), .reset(reset), .width(width), .height(height), .num_frame(num_frame),
    .start(start), .mem_rden(mem_rden), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data), .fifo_full(fifo_full),
    .out_sof(out_sof), .out_eol(out_eol), .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  image_reader #(.DWIDTH(DW), .AWIDTH(AW2)) u_dut_wrap (
    .clock(clock), .reset(reset), .width(width), .height(height), .num_frame(num_frame),
    .start(start), .mem_rden(mem_rden2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
    .fifo_wrreq(fifo_wrreq2), .fifo_data(fifo_data2), .fifo_full(fifo_full),
    .out_sof(out_sof2), .out_eol(out_eol2), .busy(busy2), .done(done2), .frame_cnt(frame_cnt2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference stream: frame f, row y, column x lives at word f*W*H + y*W + x,
  // and the memory returns its own address as pixel data.
  task automatic push_model(input int w, input int h, input int n);
    exp_t e;
    logic [AW-1:0] a;
    for (int f = 0; f < n; f++)
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++) begin
          a      = AW'(f * w * h + y * w + x);
          e.data = DW'(a);
          e.sof  = (x == 0) && (y == 0);
          e.eol  = (x == w - 1);
          e.last = (f == n - 1) && (y == h - 1) && (x == w - 1);
          sb.push_back(e);
        end
  endtask

  function automatic logic full_value(input int mode, input int k);
    if (mode == 1) return logic'((k / 2) % 2);
    if (mode == 2) return ($urandom_range(0, 9) < 4);
    return 1'b0;
  endfunction

  // Memory model: data for a read sampled in one cycle appears the next.
  initial begin : mem_model
    logic          rd1, rd2;
    logic [AW-1:0] a1;
    logic [AW2-1:0] a2;
    mem_rdata  = '0;
    mem_rdata2 = '0;
    forever begin
      @(negedge clock);
      rd1 = mem_rden; a1 = mem_addr; rd2 = mem_rden2; a2 = mem_addr2;
      @(posedge clock);
      #1;
      mem_rdata  = rd1 ? DW'(a1) : DW'($urandom);
      mem_rdata2 = rd2 ? DW'(a2) : DW'($urandom);
    end
  end

  // Monitor: scoreboard pops on every FIFO write, done/frame_cnt checks,
  // and address/data tracking of the narrow-address instance.
  initial begin : monitor
    exp_t           e;
    bit             done_due;
    logic [AW2-1:0] exp_a2, exp_w2;
    done_due = 0;
    exp_a2   = '0;
    exp_w2   = '0;
    forever begin
      @(negedge clock);
      if (done_due) begin
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        check("frame_cnt_at_done", frame_cnt, cur_n);
        done_due = 0;
      end else if (done && !zero_done_ok) begin
        check("spurious_done", done, 0);
      end
      if (fifo_wrreq) begin
        check("write_while_full", fifo_full, 0);
        if (sb.size() == 0) begin
          check("unexpected_write", fifo_wrreq, 0);
        end else begin
          e = sb.pop_front();
          check("pixel_data", fifo_data, e.data);
          check("out_sof", out_sof, e.sof);
          check("out_eol", out_eol, e.eol);
          if (e.last) done_due = 1;
        end
      end
      if (start && !busy2) begin
        exp_a2 = '0;
        exp_w2 = '0;
      end
      if (mem_rden2) begin
        check("wrap_addr", mem_addr2, exp_a2);
        exp_a2 = exp_a2 + AW2'(1);
        rd2_cnt++;
      end
      if (fifo_wrreq2) begin
        check("wrap_data", fifo_data2, DW'(exp_w2));
        exp_w2 = exp_w2 + AW2'(1);
        wr2_cnt++;
      end
      check("wrap_ctrl", {busy2, done2, out_sof2, out_eol2, frame_cnt2},
                         {busy, done, out_sof, out_eol, frame_cnt});
    end
  end

  task automatic start_job(input int w, input int h, input int n);
    @(posedge clock);
    #1;
    width     = 11'(w);
    height    = 11'(h);
    num_frame = 11'(n);
    fifo_full = 1'b0;
    start     = 1'b1;
    cur_n     = n;
    if (w > 0 && h > 0 && n > 0) push_model(w, h, n);
  endtask

  task automatic run_job(input int mode, input int budget, output int cycles,
                         output int first_rd, output int first_wr);
    bit got;
    got = 0; cycles = 0; first_rd = -1; first_wr = -1;
    while (!got && cycles < budget) begin
      @(posedge clock);
      #1;
      start     = 1'b0;
      fifo_full = full_value(mode, cycles + 1);
      @(negedge clock);
      cycles++;
      if (mem_rden && first_rd < 0) first_rd = cycles;
      if (fifo_wrreq && first_wr < 0) first_wr = cycles;
      if (done) got = 1;
    end
    check("job_finished", got, 1);
  endtask

  initial begin : stimulus
    int cyc, frd, fwr, base_rd, base_wr, w, h, n;
    reset = 1'b1; start = 1'b0; fifo_full = 1'b0;
    width = '0; height = '0; num_frame = '0;
    repeat (2) @(negedge clock);
    check("rst_outputs", {mem_rden, fifo_wrreq, out_sof, out_eol, busy, done}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", fifo_data, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    reset = 1'b0;

    // Basic 4x2 frame, FIFO always ready.
    start_job(4, 2, 1);
    run_job(0, 60, cyc, frd, fwr);
    check("t1_first_rden_cycle", frd, 1);
    check("t1_first_wrreq_cycle", fwr, 2);
    check("t1_done_cycle", cyc, 10);

    // Two 3x3 frames with full toggling every two cycles.
    start_job(3, 3, 2);
    run_job(1, 200, cyc, frd, fwr);

    // Full rises exactly when the first read returns.
    start_job(4, 1, 1);
    @(posedge clock); #1; start = 1'b0; fifo_full = 1'b0;
    @(negedge clock); check("t3_first_read", mem_rden, 1);
    @(posedge clock); #1; fifo_full = 1'b1;
    @(negedge clock); check("t3_stall_a", {mem_rden, fifo_wrreq}, 0);
    @(posedge clock); #1; fifo_full = 1'b1;
    @(negedge clock); check("t3_stall_b", {mem_rden, fifo_wrreq}, 0);
    @(posedge clock); #1; fifo_full = 1'b0;
    @(negedge clock); check("t3_hold_flush", {mem_rden, fifo_wrreq}, 2'b01);
    @(posedge clock); #1;
    @(negedge clock); check("t3_read_resume", mem_rden, 1);
    run_job(0, 40, cyc, frd, fwr);

    // Zero height: immediate done, no traffic.
    zero_done_ok = 1;
    start_job(3, 0, 2);
    @(posedge clock); #1; start = 1'b0;
    @(negedge clock);
    check("t4_done", done, 1);
    check("t4_no_traffic", {mem_rden, fifo_wrreq, busy}, 0);
    @(posedge clock); #1;
    @(negedge clock);
    check("t4_done_single", done, 0);
    check("t4_still_idle", {mem_rden, fifo_wrreq, busy}, 0);
    zero_done_ok = 0;

    // Reset in the middle of frame 2 of 3, then replay from address 0.
    start_job(3, 2, 3);
    repeat (9) begin
      @(posedge clock); #1; start = 1'b0;
      @(negedge clock);
    end
    check("t5_mid_frame", frame_cnt, 1);
    @(posedge clock); #2;
    reset = 1'b1;
    sb.delete();
    #1;
    check("t5_rst_ctrl", {mem_rden, fifo_wrreq, out_sof, out_eol, busy, done}, 0);
    check("t5_rst_addr", mem_addr, 0);
    check("t5_rst_data", fifo_data, 0);
    check("t5_rst_frame_cnt", frame_cnt, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("t5_needs_start", {busy, mem_rden}, 0);
    end
    start_job(2, 2, 1);
    run_job(0, 40, cyc, frd, fwr);
    check("t5_replay_cycles", cyc, 6);

    // Address wrap on the 4-bit instance: 18 reads cross 15 -> 0.
    base_rd = rd2_cnt;
    base_wr = wr2_cnt;
    start_job(3, 3, 2);
    run_job(0, 60, cyc, frd, fwr);
    check("t6_wrap_reads", rd2_cnt - base_rd, 18);
    check("t6_wrap_writes", wr2_cnt - base_wr, 18);
    check("t6_no_gap", cyc, 20);

    // Randomized geometries with random backpressure.
    for (int i = 0; i < 6; i++) begin
      w = $urandom_range(1, 5);
      h = $urandom_range(1, 4);
      n = $urandom_range(1, 3);
      start_job(w, h, n);
      run_job(2, 16 * w * h * n + 40, cyc, frd, fwr);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
